// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and types. The data width and the
//                default transmit-FIFO geometry are used by uart_tx_fifo
//                and kept here so uart_rx/uart_tx agree on them.
//  Contents    : UART_DW        byte width on the UART data paths
//                FIFO_DEPTH     default FIFO entries (power of two, >= 2)
//                FIFO_AF_LEVEL  default almost-full threshold
//                uart_byte_t    one UART data byte
//                count_width()  bits needed to hold 0..depth
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DW       = 8;
  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_AF_LEVEL = 12;

  typedef logic [UART_DW-1:0] uart_byte_t;

  // Occupancy runs 0..depth inclusive, so one more code than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Bundle of the CPU write port, the uart_tx valid/ready port
//                and the status outputs of the UART transmit FIFO.
//  Modports    : slave   the FIFO itself
//                master  the surroundings (CPU register port + uart_tx)
//  Signals     : wr_en, wr_data, flush, ovf_clr   CPU -> FIFO
//                tx_ready                         uart_tx -> FIFO
//                tx_data, tx_data_valid           FIFO -> uart_tx
//                full, empty, almost_full,
//                count, overflow                  FIFO -> CPU status
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) ();

  localparam int CW = count_width(DEPTH);

  // CPU write side
  logic          wr_en;
  uart_byte_t    wr_data;
  logic          flush;
  logic          ovf_clr;

  // uart_tx side
  uart_byte_t    tx_data;
  logic          tx_data_valid;
  logic          tx_ready;

  // status
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_ready,
    output tx_data, tx_data_valid, full, empty, almost_full, count, overflow
  );

  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_ready,
    input  tx_data, tx_data_valid, full, empty, almost_full, count, overflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x DW register array, synchronous write, asynchronous
//                read. Storage is deliberately not reset; the owner tracks
//                which entries are meaningful.
//  Ports       : clk    in   clock
//                we     in   write enable
//                waddr  in   write address
//                wdata  in   write data
//                raddr  in   read address
//                rdata  out  mem[raddr], combinational
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DW    = UART_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [DW-1:0] wdata,
  input  wire logic [AW-1:0] raddr,
  output logic      [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : First-word-fall-through byte FIFO between the CPU UART
//                transmit register and the uart_tx serialiser. Exposes
//                occupancy, full/empty/almost-full and a sticky overflow
//                flag so firmware can poll fill state.
//  Ports       : clk    in   system clock
//                rst_n  in   asynchronous active-low reset
//                bus    uart_tx_fifo_if.slave
//                       wr_en/wr_data/flush/ovf_clr  CPU controls
//                       tx_data/tx_data_valid        head byte to uart_tx
//                       tx_ready                     uart_tx accept
//                       full/empty/almost_full/count/overflow status
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          ovf;

  // --------------------------------------------------------------------------
  // Handshake decode. Everything here is derived from registered count, so
  // the status outputs carry no path from wr_en or tx_ready.
  // --------------------------------------------------------------------------
  logic          is_empty;
  logic          is_full;
  logic          valid;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] cnt_next;
  uart_byte_t    head;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_DEPTH);
  assign valid    = !is_empty;
  assign pop      = valid && bus.tx_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = bus.wr_en && (!is_full || pop);
  assign drop     = bus.wr_en && is_full && !pop;

  always_comb begin
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_ONE;
      2'b01:   cnt_next = cnt - CNT_ONE;
      default: cnt_next = cnt;
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage. A flush in the same cycle discards the write, so the array is
  // not written either; that keeps a stale byte from sitting at entry 0.
  // --------------------------------------------------------------------------
  fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (UART_DW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !bus.flush),
    .waddr (wp),
    .wdata (bus.wr_data),
    .raddr (rp),
    .rdata (head)
  );

  // --------------------------------------------------------------------------
  // Pointers and count. Flush wins over any push/pop in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_ONE;
      end
      if (pop) begin
        rp <= rp + PTR_ONE;
      end
      cnt <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow. A drop has priority over a clear in the same cycle so a
  // loss is never silently hidden. A write discarded by flush is not a drop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop && !bus.flush) begin
      ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The head byte is masked while empty because the storage has no
  // reset; this gives the defined 8'h00 out of reset and after a flush.
  // --------------------------------------------------------------------------
  assign bus.tx_data       = valid ? head : '0;
  assign bus.tx_data_valid = valid;
  assign bus.full          = is_full;
  assign bus.empty         = is_empty;
  assign bus.almost_full   = (cnt >= CNT_AF);
  assign bus.count         = cnt;
  assign bus.overflow      = ovf;

endmodule
`default_nettype wire
